// File: rtl/imp_axis_divider.sv
// AXI-Stream unsigned divider: two independently handshaken operands, a
// radix-2 restoring divide (one quotient bit per cycle) and a held result.
module imp_axis_divider #(
  parameter int DIVIDEND_WIDTH = 19,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rstn,
  input  logic                                    s_axis_dividend_tvalid,
  output logic                                    s_axis_dividend_tready,
  input  logic [DIVIDEND_WIDTH-1:0]               s_axis_dividend_tdata,
  input  logic                                    s_axis_divisor_tvalid,
  output logic                                    s_axis_divisor_tready,
  input  logic [DIVISOR_WIDTH-1:0]                s_axis_divisor_tdata,
  output logic                                    m_axis_dout_tvalid,
  input  logic                                    m_axis_dout_tready,
  output logic [DIVIDEND_WIDTH+DIVISOR_WIDTH-1:0] m_axis_dout_tdata,
  output logic                                    m_axis_dout_tuser
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                                  state_q;
  logic                                    have_dd_q;
  logic                                    have_dv_q;
  logic [DIVIDEND_WIDTH-1:0]               dividend_q;
  logic [DIVISOR_WIDTH-1:0]                divisor_q;
  logic [DIVIDEND_WIDTH-1:0]               quo_q;
  logic [DIVISOR_WIDTH-1:0]                rem_q;
  logic [CW-1:0]                           cnt_q;
  logic                                    tvalid_q;
  logic [DIVIDEND_WIDTH+DIVISOR_WIDTH-1:0] tdata_q;
  logic                                    tuser_q;

  logic                                    dd_fire;
  logic                                    dv_fire;
  logic                                    start;
  logic [DIVIDEND_WIDTH-1:0]               dd_next;
  logic [DIVISOR_WIDTH-1:0]                dv_next;

  logic [DIVISOR_WIDTH:0]                  trial;
  logic [DIVISOR_WIDTH:0]                  diff;
  logic                                    qbit;
  logic [DIVISOR_WIDTH-1:0]                rem_d;
  logic [DIVIDEND_WIDTH-1:0]               quo_d;

  assign s_axis_dividend_tready = (state_q == IDLE) && !have_dd_q;
  assign s_axis_divisor_tready  = (state_q == IDLE) && !have_dv_q;

  assign dd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dv_fire = s_axis_divisor_tvalid  && s_axis_divisor_tready;

  // An operand arriving on the same edge as the division starts is taken
  // straight from the bus rather than from its holding register.
  assign dd_next = have_dd_q ? dividend_q : s_axis_dividend_tdata;
  assign dv_next = have_dv_q ? divisor_q  : s_axis_divisor_tdata;
  assign start   = (state_q == IDLE) && (have_dd_q || dd_fire) && (have_dv_q || dv_fire);

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;
  assign m_axis_dout_tuser  = tuser_q;

  // A zero divisor needs no special case: every trial subtract succeeds, so the
  // quotient fills with ones and the remainder ends as the dividend's low bits.
  always_comb begin
    trial = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
    diff  = trial - {1'b0, divisor_q};
    qbit  = (trial >= {1'b0, divisor_q});
    rem_d = qbit ? diff[DIVISOR_WIDTH-1:0] : trial[DIVISOR_WIDTH-1:0];
    quo_d = {quo_q[DIVIDEND_WIDTH-2:0], qbit};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      have_dd_q  <= 1'b0;
      have_dv_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dd_fire) begin
            have_dd_q  <= 1'b1;
            dividend_q <= s_axis_dividend_tdata;
          end
          if (dv_fire) begin
            have_dv_q <= 1'b1;
            divisor_q <= s_axis_divisor_tdata;
          end
          if (start) begin
            state_q   <= CALC;
            quo_q     <= dd_next;
            divisor_q <= dv_next;
            rem_q     <= '0;
            cnt_q     <= CW'(DIVIDEND_WIDTH - 1);
          end
        end
        CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q  <= OUT;
            tvalid_q <= 1'b1;
            tdata_q  <= {rem_d, quo_d};
            tuser_q  <= (divisor_q == '0);
          end
        end
        OUT: begin
          if (m_axis_dout_tready) begin
            state_q   <= IDLE;
            tvalid_q  <= 1'b0;
            have_dd_q <= 1'b0;
            have_dv_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imp_axis_divider.sv
// Scoreboard bench for imp_axis_divider: stimulus pushes expected results,
// an independent monitor pops and checks them along with handshake timing.
module tb_imp_axis_divider;

  localparam int DW = 19;
  localparam int VW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dd_tvalid;
  logic              dd_tready;
  logic [DW-1:0]     dd_tdata;
  logic              dv_tvalid;
  logic              dv_tready;
  logic [VW-1:0]     dv_tdata;
  logic              out_tvalid;
  logic              out_ready;
  logic [DW+VW-1:0]  out_tdata;
  logic              out_tuser;

  int                cyc = 0;
  int                vecs = 0;
  int                miscmp = 0;
  int                timeouts = 0;
  bit                rand_bp = 1'b0;

  logic [DW+VW-1:0]  exp_data_q[$];
  logic              exp_user_q[$];
  int                exp_lat_q[$];

  imp_axis_divider dut (
    .i_clk                  (clk),
    .i_rstn                 (rst_n),
    .s_axis_dividend_tvalid (dd_tvalid),
    .s_axis_dividend_tready (dd_tready),
    .s_axis_dividend_tdata  (dd_tdata),
    .s_axis_divisor_tvalid  (dv_tvalid),
    .s_axis_divisor_tready  (dv_tready),
    .s_axis_divisor_tdata   (dv_tdata),
    .m_axis_dout_tvalid     (out_tvalid),
    .m_axis_dout_tready     (out_ready),
    .m_axis_dout_tdata      (out_tdata),
    .m_axis_dout_tuser      (out_tuser)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones
  // quotient and the dividend's low byte as remainder.
  task automatic push_expected(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = '1;
      r = a[VW-1:0];
    end else begin
      q = DW'(ai / bi);
      r = VW'(ai % bi);
    end
    exp_data_q.push_back({r, q});
    exp_user_q.push_back(bi == 0);
  endtask

  // Monitor: the only process that makes comparisons.
  initial begin
    bit              got_dd = 0, got_dv = 0, prev_v = 0, prev_hs = 0, both_before;
    logic [DW+VW-1:0] prev_data = '0;
    logic             prev_user = 0;
    int               seen_to = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_tvalid", {31'b0, out_tvalid}, 32'd0);
        chk("reset_tdata", 32'(out_tdata), 32'd0);
        chk("reset_tuser", {31'b0, out_tuser}, 32'd0);
        got_dd = 0; got_dv = 0; prev_v = 0; prev_hs = 0;
        exp_lat_q.delete();
      end else begin
        chk("dividend_tready", {31'b0, dd_tready}, {31'b0, !got_dd});
        chk("divisor_tready", {31'b0, dv_tready}, {31'b0, !got_dv});
        if (prev_hs) chk("tvalid_after_handshake", {31'b0, out_tvalid}, 32'd0);
        if (out_tvalid) begin
          if (!prev_v) begin
            chk("result_latency_known", {31'b0, exp_lat_q.size() != 0}, 32'd1);
            if (exp_lat_q.size() != 0) chk("result_latency", cyc, exp_lat_q.pop_front());
          end else if (!prev_hs) begin
            chk("hold_tdata", 32'(out_tdata), 32'(prev_data));
            chk("hold_tuser", {31'b0, out_tuser}, {31'b0, prev_user});
          end
          if (out_ready) begin
            chk("result_expected", {31'b0, exp_data_q.size() != 0}, 32'd1);
            if (exp_data_q.size() != 0) begin
              chk("tdata", 32'(out_tdata), 32'(exp_data_q.pop_front()));
              chk("tuser", {31'b0, out_tuser}, {31'b0, exp_user_q.pop_front()});
            end
          end
        end
        both_before = got_dd && got_dv;
        if (dd_tvalid && dd_tready) got_dd = 1;
        if (dv_tvalid && dv_tready) got_dv = 1;
        if (!both_before && got_dd && got_dv) exp_lat_q.push_back(cyc + 1 + DW);
        prev_hs = out_tvalid && out_ready;
        if (prev_hs) begin
          got_dd = 0;
          got_dv = 0;
        end
        prev_v    = out_tvalid;
        prev_data = out_tdata;
        prev_user = out_tuser;
      end
      if (timeouts != seen_to) begin
        chk("handshake_timeout", timeouts, seen_to);
        seen_to = timeouts;
      end
    end
  end

  task automatic send_pair(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input int da, input int db, input bit push_exp);
    bit dd_done = 0, dv_done = 0;
    int t = 0;
    if (push_exp) push_expected(a, b);
    while (!(dd_done && dv_done) && t < 300) begin
      dd_tvalid = !dd_done && (t >= da);
      dd_tdata  = a;
      dv_tvalid = !dv_done && (t >= db);
      dv_tdata  = b;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (dd_tvalid && dd_tready) dd_done = 1;
      if (dv_tvalid && dv_tready) dv_done = 1;
      @(posedge clk);
      #1;
      t++;
    end
    dd_tvalid = 1'b0;
    dv_tvalid = 1'b0;
    if (!(dd_done && dv_done)) timeouts++;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while ((exp_data_q.size() != 0 || out_tvalid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) timeouts++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int            k, t;
    rst_n     = 1'b0;
    dd_tvalid = 1'b0;
    dd_tdata  = '0;
    dv_tvalid = 1'b0;
    dv_tdata  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_pair(19'd1000, 8'd8, 0, 0, 1);
    drain();
    send_pair(19'd1003, 8'd8, 3, 0, 1);
    drain();
    send_pair(19'd77, 8'd0, 0, 0, 1);
    drain();

    out_ready = 1'b0;
    send_pair(19'd524287, 8'd1, 0, 0, 1);
    t = 0;
    while (!out_tvalid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) timeouts++;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    send_pair(19'd300000, 8'd7, 0, 0, 0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pair(19'd255, 8'd16, 0, 0, 1);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = DW'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0)      b = 8'd1;
      else if (k == 1) b = 8'd255;
      else if (k == 2) b = 8'd0;
      else             b = VW'($urandom);
      send_pair(a, b, $urandom_range(0, 2), $urandom_range(0, 2), 1);
    end
    rand_bp = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
